// File: rtl/mux_reg_n.sv
// Selectable storage/shift register: WIDTH-bit register loaded from one of NCH channels,
// with hold/load/shift/rotate modes, change flag and sticky select error. Optional q_par via MUX_REG_N_PARITY_EN.
module mux_reg_n #(
    parameter int unsigned WIDTH = 8,
    parameter int unsigned NCH   = 4,
    parameter int unsigned SELW  = 2
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic [NCH*WIDTH-1:0]   din,
    input  logic [SELW-1:0]        sel,
    input  logic [1:0]             mode,
    input  logic                   en,
    input  logic                   ser_in,
    output logic [WIDTH-1:0]       q,
    output logic                   ser_out,
    output logic                   q_chg,
`ifdef MUX_REG_N_PARITY_EN
    output logic                   q_par,
`endif
    output logic                   sel_err
);

    localparam logic [1:0] MODE_HOLD   = 2'b00;
    localparam logic [1:0] MODE_LOAD   = 2'b01;
    localparam logic [1:0] MODE_SHIFT  = 2'b10;
    localparam logic [1:0] MODE_ROTATE = 2'b11;

    logic [WIDTH-1:0] chan_sel_c;
    logic             sel_ok_c;
    logic [WIDTH-1:0] q_nxt_c;
    logic             ser_nxt_c;
    logic             err_nxt_c;

    // Channel pick; out-of-range selects leave sel_ok_c low instead of indexing past din
    always_comb begin
        chan_sel_c = '0;
        sel_ok_c   = 1'b0;
        for (int unsigned k = 0; k < NCH; k++) begin
            if (sel == SELW'(k)) begin
                chan_sel_c = din[k*WIDTH +: WIDTH];
                sel_ok_c   = 1'b1;
            end
        end
    end

    // Next-state of the register, serial output and error flag
    always_comb begin
        q_nxt_c   = q;
        ser_nxt_c = ser_out;
        err_nxt_c = sel_err;
        if (en) begin
            case (mode)
                MODE_HOLD: begin
                    q_nxt_c = q;
                end
                MODE_LOAD: begin
                    if (sel_ok_c) q_nxt_c   = chan_sel_c;
                    else          err_nxt_c = 1'b1;
                end
                MODE_SHIFT: begin
                    q_nxt_c   = {q[WIDTH-2:0], ser_in};
                    ser_nxt_c = q[WIDTH-1];
                end
                MODE_ROTATE: begin
                    q_nxt_c   = {q[WIDTH-2:0], q[WIDTH-1]};
                    ser_nxt_c = q[WIDTH-1];
                end
                default: begin
                    q_nxt_c = q;
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            q       <= '0;
            ser_out <= 1'b0;
            q_chg   <= 1'b0;
            sel_err <= 1'b0;
        end else begin
            q       <= q_nxt_c;
            ser_out <= ser_nxt_c;
            q_chg   <= (q_nxt_c != q);
            sel_err <= err_nxt_c;
        end
    end

`ifdef MUX_REG_N_PARITY_EN
    // Parity tracks q; recomputing it when q holds yields the same value
    always_ff @(posedge clk) begin
        if (!rst) q_par <= 1'b0;
        else      q_par <= ^q_nxt_c;
    end
`endif

endmodule

// File: tb/tb_mux_reg_n.sv
// Self-checking bench for mux_reg_n: directed plan steps plus random steps against an arithmetic model.
// Instantiates a default (NCH=4) and an NCH=3 copy so out-of-range selects can be exercised.
module tb_mux_reg_n;

    logic        clk = 1'b0;
    logic        rst;
    logic        en;
    logic        ser_in;
    logic [1:0]  mode;
    logic [1:0]  sel;
    logic [31:0] din;
    logic [23:0] din3;
    logic [7:0]  q_a, q_b;
    logic        ser_a, ser_b, chg_a, chg_b, err_a, err_b;
`ifdef MUX_REG_N_PARITY_EN
    logic        par_a, par_b;
`endif

    int n_cmp = 0;
    int n_bad = 0;

    // Reference state per instance: index 0 = NCH 4, index 1 = NCH 3
    int unsigned mq[2];
    bit          mser[2], mchg[2], merr[2], mpar[2];

    always #5 clk = ~clk;
    assign din3 = din[23:0];

    mux_reg_n #(.WIDTH(8), .NCH(4), .SELW(2)) dut_a (
        .clk(clk), .rst(rst), .din(din), .sel(sel), .mode(mode), .en(en),
        .ser_in(ser_in), .q(q_a), .ser_out(ser_a), .q_chg(chg_a),
`ifdef MUX_REG_N_PARITY_EN
        .q_par(par_a),
`endif
        .sel_err(err_a)
    );

    mux_reg_n #(.WIDTH(8), .NCH(3), .SELW(2)) dut_b (
        .clk(clk), .rst(rst), .din(din3), .sel(sel), .mode(mode), .en(en),
        .ser_in(ser_in), .q(q_b), .ser_out(ser_b), .q_chg(chg_b),
`ifdef MUX_REG_N_PARITY_EN
        .q_par(par_b),
`endif
        .sel_err(err_b)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        assert (got === exp) else begin
            n_bad++;
            $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic model_update(input bit r, input bit e, input bit [1:0] md,
                                input bit [1:0] s, input bit si, input bit [31:0] d);
        int unsigned old, nq, nch;
        for (int i = 0; i < 2; i++) begin
            nch = (i == 0) ? 4 : 3;
            old = mq[i];
            if (!r) begin
                mq[i] = 0; mser[i] = 0; mchg[i] = 0; merr[i] = 0; mpar[i] = 0;
            end else begin
                nq = old;
                if (e) begin
                    if (md == 2'd1) begin
                        if (s < nch) nq = (d >> (8 * s)) & 32'hFF;
                        else         merr[i] = 1'b1;
                    end else if (md == 2'd2) begin
                        mser[i] = bit'((old >> 7) & 1);
                        nq      = ((old * 2) + si) % 256;
                    end else if (md == 2'd3) begin
                        mser[i] = bit'((old >> 7) & 1);
                        nq      = ((old * 2) + (old / 128)) % 256;
                    end
                end
                mchg[i] = (nq != old);
                mpar[i] = bit'($countones(nq) % 2);
                mq[i]   = nq;
            end
        end
    endtask

    task automatic check_all();
        check("a_q",   32'(q_a),   mq[0]);
        check("a_ser", 32'(ser_a), 32'(mser[0]));
        check("a_chg", 32'(chg_a), 32'(mchg[0]));
        check("a_err", 32'(err_a), 32'(merr[0]));
        check("b_q",   32'(q_b),   mq[1]);
        check("b_ser", 32'(ser_b), 32'(mser[1]));
        check("b_chg", 32'(chg_b), 32'(mchg[1]));
        check("b_err", 32'(err_b), 32'(merr[1]));
`ifdef MUX_REG_N_PARITY_EN
        check("a_par", 32'(par_a), 32'(mpar[0]));
        check("b_par", 32'(par_b), 32'(mpar[1]));
`endif
    endtask

    // Drive one cycle, check 5 time units after the edge, then float inputs to X
    task automatic step(input bit r, input bit e, input bit [1:0] md,
                        input bit [1:0] s, input bit si, input bit [31:0] d);
        rst = r; en = e; mode = md; sel = s; ser_in = si; din = d;
        @(posedge clk);
        model_update(r, e, md, s, si, d);
        #5;
        check_all();
        rst = 1'bx; en = 1'bx; mode = 'x; sel = 'x; ser_in = 1'bx; din = 'x;
        #2;
    endtask

    initial begin
        // Reset overrides an enabled load
        step(0, 1, 2'd1, 2'd0, 0, 32'hFFFF_FFFF);
        check("rst_q", 32'(q_a), 32'h00);
        check("rst_err", 32'(err_b), 32'h0);

        // Load each channel in turn, then reload the same value
        step(1, 1, 2'd1, 2'd0, 0, 32'h4433_2211);
        check("ld0_q", 32'(q_a), 32'h11);
        step(1, 1, 2'd1, 2'd1, 0, 32'h4433_2211);
        check("ld1_q", 32'(q_a), 32'h22);
        step(1, 1, 2'd1, 2'd2, 0, 32'h4433_2211);
        check("ld2_q", 32'(q_a), 32'h33);
        step(1, 1, 2'd1, 2'd3, 0, 32'h4433_2211);
        check("ld3_q", 32'(q_a), 32'h44);
        check("ld3_chg", 32'(chg_a), 32'h1);
        step(1, 1, 2'd1, 2'd3, 0, 32'h4433_2211);
        check("reld_chg", 32'(chg_a), 32'h0);

        // Shift from 0x81
        step(1, 1, 2'd1, 2'd0, 0, 32'h0000_0081);
        step(1, 1, 2'd2, 2'd3, 0, 32'h0);
        check("sh1_q", 32'(q_a), 32'h02);
        check("sh1_ser", 32'(ser_a), 32'h1);
        step(1, 1, 2'd2, 2'd1, 1, 32'h0);
        check("sh2_q", 32'(q_a), 32'h05);
        check("sh2_ser", 32'(ser_a), 32'h0);

        // Rotate, then disabled rotate holds
        step(1, 1, 2'd1, 2'd0, 0, 32'h0000_0081);
        step(1, 1, 2'd3, 2'd0, 0, 32'h0);
        check("rot_q", 32'(q_a), 32'h03);
        check("rot_ser", 32'(ser_a), 32'h1);
        step(1, 0, 2'd3, 2'd0, 0, 32'h0);
        check("en0_q", 32'(q_a), 32'h03);
        check("en0_chg", 32'(chg_a), 32'h0);

        // Rotating all-ones does not flag a change
        step(1, 1, 2'd1, 2'd0, 0, 32'h0000_00FF);
        step(1, 1, 2'd3, 2'd0, 0, 32'h0);
        check("rotff_chg", 32'(chg_a), 32'h0);

        // Select error on the 3-channel instance
        step(1, 1, 2'd1, 2'd0, 0, 32'h0000_005A);
        step(1, 1, 2'd1, 2'd3, 0, 32'h4433_2211);
        check("serr_q", 32'(q_b), 32'h5A);
        check("serr_set", 32'(err_b), 32'h1);
        check("serr_a", 32'(q_a), 32'h44);
        step(1, 1, 2'd1, 2'd1, 0, 32'h4433_2211);
        check("serr_sticky", 32'(err_b), 32'h1);
        step(0, 1, 2'd1, 2'd3, 0, 32'h4433_2211);
        check("serr_clr", 32'(err_b), 32'h0);

        // Reset in the middle of a shift sequence
        step(1, 1, 2'd1, 2'd0, 0, 32'h0000_00FF);
        step(1, 1, 2'd2, 2'd0, 0, 32'h0);
        step(0, 1, 2'd2, 2'd0, 1, 32'h0);
        step(1, 1, 2'd2, 2'd0, 1, 32'h0);
        check("rstsh_q", 32'(q_a), 32'h01);
        check("rstsh_ser", 32'(ser_a), 32'h0);

`ifdef MUX_REG_N_PARITY_EN
        step(1, 1, 2'd1, 2'd0, 0, 32'h0000_0007);
        check("par07", 32'(par_a), 32'h1);
        step(1, 1, 2'd1, 2'd0, 0, 32'h0000_0003);
        check("par03", 32'(par_a), 32'h0);
        step(0, 1, 2'd1, 2'd0, 0, 32'h0000_0007);
        check("par_rst", 32'(par_a), 32'h0);
`endif

        // Random traffic with rare resets
        for (int i = 0; i < 400; i++) begin
            step(bit'($urandom_range(0, 24) != 0), bit'($urandom_range(0, 3) != 0),
                 2'($urandom), 2'($urandom), 1'($urandom), $urandom);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/mux_reg_n.md
Name: mux_reg_n

Overview:
- Parametrised successor to the team's 2:1 muxed D flip-flop.
- A WIDTH-bit register fed from one of NCH data channels.
- Adds clock enable, four operating modes (hold, load, shift, rotate), a one-cycle change flag and a sticky select-error flag.
- Used as the general-purpose selectable storage/shift element in datapath blocks.

Parameters:
- WIDTH, 8, register and per-channel data width (>=2)
- NCH, 4, number of input data channels (>=2)
- SELW, 2, select width; must satisfy 2**SELW >= NCH

Ports:
- clk  input  1  rising-edge clock
- rst  input  1  synchronous reset, active-low
- din  input  NCH*WIDTH  packed channels; channel k = din[k*WIDTH +: WIDTH]
- sel  input  SELW  channel select for LOAD mode
- mode  input  2  00 HOLD, 01 LOAD, 10 SHIFT, 11 ROTATE
- en  input  1  clock enable; 0 forces hold of every register
- ser_in  input  1  serial input bit for SHIFT
- q  output  WIDTH  registered data
- ser_out  output  1  registered; bit shifted out by the last SHIFT/ROTATE
- q_chg  output  1  registered; high one cycle when q changed on the previous edge
- sel_err  output  1  sticky; set by LOAD with sel >= NCH

Behaviour:
- Clock and reset: one clock (clk). rst is synchronous, active-low, sampled on posedge clk only. There is no asynchronous path.
- Reset: on any edge where rst=0, q=0, ser_out=0, q_chg=0 and sel_err=0. Reset overrides en and mode.
- Latency: all outputs are registered. An input sampled at edge N appears on outputs after edge N.
- en=0:
  - q, ser_out and sel_err hold.
  - q_chg=0 on that edge.
- en=1, HOLD: q holds; ser_out holds.
- en=1, LOAD, sel < NCH: q <= channel sel; ser_out holds.
- en=1, LOAD, sel >= NCH:
  - q holds; sel_err <= 1.
  - sel_err stays 1 until reset.
- en=1, SHIFT: q <= {q[WIDTH-2:0], ser_in}; ser_out <= q[WIDTH-1] (old MSB).
- en=1, ROTATE: q <= {q[WIDTH-2:0], q[WIDTH-1]}; ser_out <= q[WIDTH-1].
- q_chg: on every non-reset edge, q_chg <= (next q != current q).
  - LOAD of a value equal to q gives q_chg=0.
  - ROTATE of all-0 or all-1 data gives q_chg=0.
- Simultaneous events: reset wins over everything. en=0 wins over mode. An invalid sel affects only LOAD; sel is ignored in the other modes.
- Reset mid-operation: a shift sequence interrupted by rst=0 leaves q=0. The next SHIFT after reset release starts from q=0.
- Unknown inputs: not checked by the RTL. The bench drives X between checks to prove that only sampled values matter.

Optional Feature:
- Macro: MUX_REG_N_PARITY_EN.
- Defined:
  - Adds output port q_par (1 bit), registered alongside q and equal to ^(next q), i.e. the XOR of the value q takes on that edge.
  - q_par resets to 0 and holds when en=0 or when q holds.
- Not defined: the q_par port and its logic are absent. Everything else is identical.

Test Plan:
- Reset: rst=0 for one edge with en=1, mode=01, din all 0xFF -> q=0x00, ser_out=0, q_chg=0, sel_err=0 five time units after the edge.
- Load all channels: din = {0x44,0x33,0x22,0x11}, sel=0..3, mode=01, en=1 -> q=0x11, 0x22, 0x33, 0x44 on successive edges; q_chg=1 after each; reloading sel=3 -> q_chg=0.
- Shift: q=0x81, mode=10, ser_in=0 -> q=0x02, ser_out=1; next edge, ser_in=1 -> q=0x05, ser_out=0.
- Rotate and enable: q=0x81, mode=11 -> q=0x03, ser_out=1; then en=0 with mode=11 -> q stays 0x03, q_chg=0.
- Select error (NCH=3, SELW=2): q=0x5A, mode=01, sel=3 -> q=0x5A, sel_err=1. A valid load then keeps sel_err=1; rst=0 clears it.
- Parity (macro defined): load 0x07 -> q_par=1; load 0x03 -> q_par=0; rst=0 -> q_par=0.
